// File: rtl/bus85_mem.sv
// Memory / I-O slave for the 8085-style multiplexed bus: decodes an aligned window,
// serves reads on addrdata, captures writes, and stretches accesses with wait states.
module bus85_mem #(
    parameter int DATASIZE = 8,
    parameter int ADDRSIZE = 16,
    parameter int MEMSIZE  = 10,
    parameter int BASEADDR = 0,
    parameter int IOSPACE  = 0,
    parameter int WAITCNT  = 0
) (
    input  logic                         clk,
    input  logic                         rst_,
    input  logic                         ale,
    input  logic                         iom_,
    input  logic                         rd_,
    input  logic                         wr_,
    input  logic [ADDRSIZE-DATASIZE-1:0] addr,
    inout  wire  [DATASIZE-1:0]          addrdata,
    output logic                         ready,
    output logic                         hit,
    output logic                         err
);

    typedef enum logic [1:0] {IDLE, SEL, WAIT, DATA} state_t;

    localparam int                  AW1    = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0]   WIN_LO = AW1'(BASEADDR);
    localparam logic [ADDRSIZE-1:0] BASE_A = ADDRSIZE'(BASEADDR);

    state_t              state_q, state_d;
    logic [ADDRSIZE-1:0] adr_q, adr_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                ready_q, ready_d;
    logic                hit_q, hit_d;
    logic                err_q, err_d;
    logic                wdone_q, wdone_d;

    logic [DATASIZE-1:0] mem [2**MEMSIZE];

    logic [ADDRSIZE-1:0] adr_in;
    logic [ADDRSIZE:0]   rel_in;
    logic                dec_hit;
    logic [MEMSIZE-1:0]  off;
    logic                drive;
    logic                mem_we;

    // One extra bit keeps the borrow, so addresses below the base never alias into the window.
    assign adr_in  = {addr, addrdata};
    assign rel_in  = {1'b0, adr_in} - WIN_LO;
    assign dec_hit = (iom_ == 1'(IOSPACE)) && ((rel_in >> MEMSIZE) == '0);
    assign off     = MEMSIZE'(adr_q - BASE_A);

    assign drive    = (state_q == DATA) && !rd_;
    assign addrdata = drive ? mem[off] : 'z;

    assign mem_we = rst_ && !ale && (state_q == DATA) && !wr_ && rd_ && !wdone_q;

    always_ff @(posedge clk) begin
        if (mem_we) mem[off] <= addrdata;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            adr_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
            wdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
            wdone_q <= wdone_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        hit_d   = hit_q;
        err_d   = err_q;
        wdone_d = wdone_q;
        if (ale) begin
            // A new address phase always wins and abandons whatever access was in flight.
            adr_d   = adr_in;
            hit_d   = dec_hit;
            state_d = dec_hit ? SEL : IDLE;
            ready_d = 1'b1;
            cnt_d   = '0;
            wdone_d = 1'b0;
        end else if (state_q != IDLE && !rd_ && !wr_) begin
            err_d   = 1'b1;
            state_d = IDLE;
            hit_d   = 1'b0;
            ready_d = 1'b1;
        end else begin
            case (state_q)
                SEL: begin
                    if (!rd_ || !wr_) begin
                        if (WAITCNT == 0) begin
                            state_d = DATA;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = 4'(WAITCNT - 1);
                            ready_d = 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_d = DATA;
                        ready_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                DATA: begin
                    if (!wr_) wdone_d = 1'b1;
                    if (rd_ && wr_) begin
                        state_d = IDLE;
                        hit_d   = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready = ready_q;
    assign hit   = hit_q;
    assign err   = err_q;

endmodule
